// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// Groups the decoder fields, ALU flag, memory handshake and every datapath
// strobe/select so the controller port list stays small.
//   master : controller side (drives strobes, reads op/funct/zero/mem_ack)
//   slave  : datapath side (drives op/funct/zero/mem_ack, reads strobes)
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       mdr_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       retire;
    logic [1:0] fault;

    modport master (
        input  op, funct, zero, mem_ack,
        output mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pc_src,
               reg_we, reg_dst, wb_sel, alu_src_b, alu_op, retire, fault
    );

    modport slave (
        output op, funct, zero, mem_ack,
        input  mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pc_src,
               reg_we, reg_dst, wb_sel, alu_src_b, alu_op, retire, fault
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle MIPS-subset CPU. Sequences fetch, decode,
// execute, memory and writeback over one shared memory port and one ALU.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high; forces every output to 0 while high
//   bus         multicycle_controller_if.master: op/funct/zero/mem_ack in,
//               memory handshake, datapath strobes/selects, retire, fault out
//   instr_count retired-instruction counter (only with MULTICYCLE_CTRL_PERF_EN)
//   stall_count memory wait-cycle counter  (only with MULTICYCLE_CTRL_PERF_EN)
//
// Parameter TIMEOUT: cycles waiting for mem_ack in FETCH/MEM before a
// memory-timeout fault; 0 disables the check. 8-bit wait counter.
//
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds the two 32-bit
// performance counters; undefined, the ports and counters are absent.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR and PC+4 on ack
// DECODE | latch op/funct; J/JR finish here, JAL skips to WB
// EXEC   | ALU operation; BNE resolves and finishes here
// MEM    | data read (LW) or write (SW) at ALU result
// WB     | register file write; JAL also loads the jump target
// HALT   | fault taken, all strobes idle until reset
module multicycle_controller #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]            instr_count,
    output logic [31:0]            stall_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        I_LW, I_SW, I_J, I_JAL, I_BNE, I_ADDI, I_XORI,
        I_ADD, I_SUB, I_SLT, I_JR, I_ILL
    } instr_t;

    localparam bit         TMO_EN  = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LIM = TIMEOUT[7:0];

    function automatic instr_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return I_LW;
            6'b101011: return I_SW;
            6'b000010: return I_J;
            6'b000011: return I_JAL;
            6'b000101: return I_BNE;
            6'b001000: return I_ADDI;
            6'b001110: return I_XORI;
            6'b000000: begin
                case (f)
                    6'b100000: return I_ADD;
                    6'b100010: return I_SUB;
                    6'b101010: return I_SLT;
                    6'b001000: return I_JR;
                    default:   return I_ILL;
                endcase
            end
            default:   return I_ILL;
        endcase
    endfunction

    state_t     state;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic [7:0] wait_cnt;
    logic [1:0] fault_q;

    instr_t     ins;
    logic [7:0] cnt_next;
    logic       tmo;

    // DECODE acts on the live decoder fields (they are being latched on
    // this same edge); later states use the latched copy.
    assign ins      = (state == S_DECODE) ? classify(bus.op, bus.funct)
                                          : classify(op_q, funct_q);
    assign cnt_next = wait_cnt + 8'd1;
    // Fires on the wait cycle that would bring the counter to the limit;
    // an ack in that same cycle takes priority in the FSM below.
    assign tmo      = TMO_EN && (cnt_next == TMO_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            op_q     <= '0;
            funct_q  <= '0;
            wait_cnt <= '0;
            fault_q  <= 2'b00;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        state <= S_DECODE;
                    end else if (tmo) begin
                        fault_q <= 2'b10;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end
                S_DECODE: begin
                    op_q    <= bus.op;
                    funct_q <= bus.funct;
                    case (ins)
                        I_J, I_JR: state <= S_FETCH;
                        I_JAL:     state <= S_WB;
                        I_ILL: begin
                            fault_q <= 2'b01;
                            state   <= S_HALT;
                        end
                        default:   state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (ins)
                        I_LW, I_SW: state <= S_MEM;
                        I_BNE:      state <= S_FETCH;
                        default:    state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ack) begin
                        state <= (ins == I_LW) ? S_WB : S_FETCH;
                    end else if (tmo) begin
                        fault_q <= 2'b10;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= cnt_next;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.ir_we     = 1'b0;
        bus.mdr_we    = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 2'b00;
        bus.reg_we    = 1'b0;
        bus.reg_dst   = 2'b00;
        bus.wb_sel    = 2'b00;
        bus.alu_src_b = 2'b00;
        bus.alu_op    = 3'b000;
        bus.retire    = 1'b0;
        bus.fault     = reset ? 2'b00 : fault_q;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        bus.ir_we = 1'b1;
                        bus.pc_we = 1'b1;
                    end
                end
                S_DECODE: begin
                    case (ins)
                        I_J: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = 2'b10;
                            bus.retire = 1'b1;
                        end
                        I_JR: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = 2'b11;
                            bus.retire = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    case (ins)
                        I_LW, I_SW, I_ADDI: bus.alu_src_b = 2'b01;
                        I_XORI: begin
                            bus.alu_src_b = 2'b10;
                            bus.alu_op    = 3'b010;
                        end
                        I_SUB: bus.alu_op = 3'b001;
                        I_SLT: bus.alu_op = 3'b011;
                        I_BNE: begin
                            bus.alu_op = 3'b001;
                            bus.retire = 1'b1;
                            if (!bus.zero) begin
                                bus.pc_we  = 1'b1;
                                bus.pc_src = 2'b01;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_we  = (ins == I_SW);
                    if (bus.mem_ack) begin
                        if (ins == I_LW) bus.mdr_we = 1'b1;
                        else             bus.retire = 1'b1;
                    end
                end
                S_WB: begin
                    bus.reg_we = 1'b1;
                    bus.retire = 1'b1;
                    case (ins)
                        I_ADD, I_SUB, I_SLT: bus.reg_dst = 2'b01;
                        I_LW: bus.wb_sel = 2'b01;
                        I_JAL: begin
                            bus.reg_dst = 2'b10;
                            bus.wb_sel  = 2'b10;
                            bus.pc_we   = 1'b1;
                            bus.pc_src  = 2'b10;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (bus.retire)                  instr_count <= instr_count + 32'd1;
            if (bus.mem_req && !bus.mem_ack) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. Each scenario pushes per-cycle
// stimulus plus the expected control vector, then drains the queue one clock
// at a time, comparing at the falling edge.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       mdr_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       retire;
        logic [1:0] fault;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       ack;
        logic       zero;
        ctl_t       exp;
    } vec_t;

    localparam logic [5:0] XX = 6'b111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t sb[$];

    multicycle_controller_if dif ();

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instr_count;
    logic [31:0] stall_count;
    multicycle_controller #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .bus(dif),
        .instr_count(instr_count), .stall_count(stall_count)
    );
`else
    multicycle_controller #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .bus(dif)
    );
`endif

    always #5 clk = ~clk;

    function automatic ctl_t sample();
        ctl_t s;
        s.mem_req   = dif.mem_req;
        s.mem_we    = dif.mem_we;
        s.iord      = dif.iord;
        s.ir_we     = dif.ir_we;
        s.mdr_we    = dif.mdr_we;
        s.pc_we     = dif.pc_we;
        s.pc_src    = dif.pc_src;
        s.reg_we    = dif.reg_we;
        s.reg_dst   = dif.reg_dst;
        s.wb_sel    = dif.wb_sel;
        s.alu_src_b = dif.alu_src_b;
        s.alu_op    = dif.alu_op;
        s.retire    = dif.retire;
        s.fault     = dif.fault;
        return s;
    endfunction

    function automatic void push(input logic [5:0] o, input logic [5:0] f,
                                 input logic a, input logic z, input ctl_t e);
        vec_t v;
        v.op = o; v.funct = f; v.ack = a; v.zero = z; v.exp = e;
        sb.push_back(v);
    endfunction

    function automatic ctl_t fetch_v(input logic ack);
        ctl_t e = '0;
        e.mem_req = 1'b1;
        e.ir_we   = ack;
        e.pc_we   = ack;
        return e;
    endfunction

    function automatic ctl_t halt_v(input logic [1:0] f);
        ctl_t e = '0;
        e.fault = f;
        return e;
    endfunction

    task automatic run_cycle(input vec_t v, output ctl_t act);
        dif.op      = v.op;
        dif.funct   = v.funct;
        dif.mem_ack = v.ack;
        dif.zero    = v.zero;
        @(negedge clk);
        act = sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack, output ctl_t act);
        dif.op      = 6'b000000;
        dif.funct   = 6'b100000;
        dif.mem_ack = ack;
        reset       = 1'b1;
        @(negedge clk);
        act = sample();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ctl_t act;
        dif.zero = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            dif.mem_ack = 1'b1;
            do_reset(1'b1, act);
            reset = 1'b1;
            n_vec++;
            if (act !== ctl_t'('0)) begin
                n_err++;
                $display("FAIL reset_outputs cyc%0d got %h want 0", i, act);
            end
        end
        reset = 1'b0;
`ifdef MULTICYCLE_CTRL_PERF_EN
        n_vec++;
        if (instr_count !== 32'd0 || stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_perf got %0d/%0d want 0/0", instr_count, stall_count);
        end
`endif
    endtask

    task automatic drain(input string name);
        vec_t v;
        ctl_t act;
        int   i = 0;
        while (sb.size() > 0) begin
            v = sb.pop_front();
            run_cycle(v, act);
            n_vec++;
            if (act !== v.exp) begin
                n_err++;
                $display("FAIL %s cyc%0d got %h want %h", name, i, act, v.exp);
            end
            i++;
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn[3];
        logic [2:0] aop[3];
        ctl_t e;
        fn[0] = 6'b100000; aop[0] = 3'b000;
        fn[1] = 6'b100010; aop[1] = 3'b001;
        fn[2] = 6'b101010; aop[2] = 3'b011;
        for (int k = 0; k < 3; k++) begin
            push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
            e = '0; push(6'b000000, fn[k], 1'b1, 1'b0, e);
            e = '0; e.alu_op = aop[k]; push(XX, XX, 1'b1, 1'b0, e);
            e = '0; e.reg_we = 1'b1; e.reg_dst = 2'b01; e.retire = 1'b1;
            push(XX, XX, 1'b1, 1'b0, e);
        end
        drain("rtype");
    endtask

    task automatic test_imm();
        ctl_t e;
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; push(6'b001000, XX, 1'b1, 1'b0, e);
        e = '0; e.alu_src_b = 2'b01; push(XX, XX, 1'b1, 1'b0, e);
        e = '0; e.reg_we = 1'b1; e.retire = 1'b1; push(XX, XX, 1'b1, 1'b0, e);
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; push(6'b001110, XX, 1'b1, 1'b0, e);
        e = '0; e.alu_src_b = 2'b10; e.alu_op = 3'b010; push(XX, XX, 1'b1, 1'b0, e);
        e = '0; e.reg_we = 1'b1; e.retire = 1'b1; push(XX, XX, 1'b1, 1'b0, e);
        drain("imm");
    endtask

    task automatic test_lw_wait();
        ctl_t e;
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; push(6'b100011, XX, 1'b1, 1'b0, e);
        e = '0; e.alu_src_b = 2'b01; push(XX, XX, 1'b1, 1'b0, e);
        for (int i = 0; i < 3; i++) begin
            e = '0; e.mem_req = 1'b1; e.iord = 1'b1; push(XX, XX, 1'b0, 1'b0, e);
        end
        e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mdr_we = 1'b1;
        push(XX, XX, 1'b1, 1'b0, e);
        e = '0; e.reg_we = 1'b1; e.wb_sel = 2'b01; e.retire = 1'b1;
        push(XX, XX, 1'b1, 1'b0, e);
        drain("lw_wait");
    endtask

    task automatic test_sw();
        ctl_t e;
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; push(6'b101011, XX, 1'b1, 1'b0, e);
        e = '0; e.alu_src_b = 2'b01; push(XX, XX, 1'b1, 1'b0, e);
        e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; e.retire = 1'b1;
        push(XX, XX, 1'b1, 1'b0, e);
        drain("sw");
    endtask

    task automatic test_bne();
        ctl_t e;
        for (int z = 0; z < 2; z++) begin
            push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
            e = '0; push(6'b000101, XX, 1'b1, 1'b0, e);
            e = '0; e.alu_op = 3'b001; e.retire = 1'b1;
            if (z == 0) begin
                e.pc_we = 1'b1; e.pc_src = 2'b01;
            end
            push(XX, XX, 1'b1, (z != 0), e);
        end
        drain("bne");
    endtask

    task automatic test_jumps();
        ctl_t e;
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; e.pc_we = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
        push(6'b000010, XX, 1'b1, 1'b0, e);
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; e.pc_we = 1'b1; e.pc_src = 2'b11; e.retire = 1'b1;
        push(6'b000000, 6'b001000, 1'b1, 1'b0, e);
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; push(6'b000011, XX, 1'b1, 1'b0, e);
        e = '0; e.reg_we = 1'b1; e.reg_dst = 2'b10; e.wb_sel = 2'b10;
        e.pc_we = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
        push(XX, XX, 1'b1, 1'b0, e);
        drain("jumps");
    endtask

    task automatic test_illegal();
        ctl_t e;
        ctl_t act;
        logic [5:0] bad_op[2];
        logic [5:0] bad_fn[2];
        bad_op[0] = 6'b111111; bad_fn[0] = 6'b100000;
        bad_op[1] = 6'b000000; bad_fn[1] = 6'b000000;
        for (int k = 0; k < 2; k++) begin
            push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
            e = '0; push(bad_op[k], bad_fn[k], 1'b1, 1'b0, e);
            for (int i = 0; i < 20; i++) push(XX, XX, 1'b1, 1'b0, halt_v(2'b01));
            drain("illegal_halt");
            do_reset(1'b1, act);
            n_vec++;
            if (act !== ctl_t'('0)) begin
                n_err++;
                $display("FAIL illegal_reset got %h want 0", act);
            end
            push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
            e = '0; e.pc_we = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
            push(6'b000010, XX, 1'b1, 1'b0, e);
            drain("illegal_recover");
        end
    endtask

    task automatic test_timeout();
        ctl_t e;
        ctl_t act;
        for (int i = 0; i < 4; i++) push(XX, XX, 1'b0, 1'b0, fetch_v(1'b0));
        for (int i = 0; i < 3; i++) push(XX, XX, 1'b1, 1'b0, halt_v(2'b10));
        drain("fetch_timeout");
        do_reset(1'b0, act);
        n_vec++;
        if (act !== ctl_t'('0)) begin
            n_err++;
            $display("FAIL timeout_reset got %h want 0", act);
        end
        for (int i = 0; i < 3; i++) push(XX, XX, 1'b0, 1'b0, fetch_v(1'b0));
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; push(6'b001000, XX, 1'b1, 1'b0, e);
        e = '0; e.alu_src_b = 2'b01; push(XX, XX, 1'b1, 1'b0, e);
        e = '0; e.reg_we = 1'b1; e.retire = 1'b1; push(XX, XX, 1'b1, 1'b0, e);
        drain("ack_at_limit");
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; push(6'b101011, XX, 1'b1, 1'b0, e);
        e = '0; e.alu_src_b = 2'b01; push(XX, XX, 1'b1, 1'b0, e);
        for (int i = 0; i < 4; i++) begin
            e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1;
            push(XX, XX, 1'b0, 1'b0, e);
        end
        for (int i = 0; i < 2; i++) push(XX, XX, 1'b1, 1'b0, halt_v(2'b10));
        drain("mem_timeout");
        do_reset(1'b0, act);
        n_vec++;
        if (act !== ctl_t'('0)) begin
            n_err++;
            $display("FAIL mem_timeout_reset got %h want 0", act);
        end
    endtask

    task automatic test_reset_mid_mem();
        ctl_t e;
        ctl_t act;
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; push(6'b101011, XX, 1'b1, 1'b0, e);
        e = '0; e.alu_src_b = 2'b01; push(XX, XX, 1'b1, 1'b0, e);
        e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1;
        push(XX, XX, 1'b0, 1'b0, e);
        drain("sw_pre_reset");
        do_reset(1'b0, act);
        n_vec++;
        if (act.mem_req !== 1'b0 || act.mem_we !== 1'b0 || act !== ctl_t'('0)) begin
            n_err++;
            $display("FAIL mid_mem_reset got %h want 0", act);
        end
        push(XX, XX, 1'b1, 1'b0, fetch_v(1'b1));
        e = '0; e.pc_we = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1;
        push(6'b000010, XX, 1'b1, 1'b0, e);
        drain("after_mid_reset");
    endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
    task automatic test_perf();
        ctl_t act;
        do_reset(1'b0, act);
        n_vec++;
        if (instr_count !== 32'd0 || stall_count !== 32'd0) begin
            n_err++;
            $display("FAIL perf_clear got %0d/%0d want 0/0", instr_count, stall_count);
        end
        test_rtype();
        test_lw_wait();
        n_vec++;
        if (instr_count !== 32'd4 || stall_count !== 32'd3) begin
            n_err++;
            $display("FAIL perf_counts got %0d/%0d want 4/3", instr_count, stall_count);
        end
    endtask
`endif

    initial begin
        dif.op      = XX;
        dif.funct   = XX;
        dif.mem_ack = 1'b0;
        dif.zero    = 1'b0;
        test_reset();
        test_rtype();
        test_imm();
        test_lw_wait();
        test_sw();
        test_bne();
        test_jumps();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
`ifdef MULTICYCLE_CTRL_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle MIPS-subset CPU.
- Sequences fetch, decode, execute, memory and writeback over one shared memory port and one ALU.
- Consumes the op and funct fields from the instruction decoder and the ALU zero flag.
- Drives every datapath enable and mux select, and handshakes with memory through req/ack.

Parameters:
TIMEOUT, 255, max cycles waiting for mem_ack in FETCH or MEM before faulting; 0 disables the timeout (counter width 8 bits).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  6  opcode field from instruction decoder (IR[31:26])
funct  input  6  function field (IR[5:0])
zero  input  1  ALU zero flag
mem_ack  input  1  memory completes the current request this cycle
mem_req  output  1  memory request
mem_we  output  1  memory write (valid with mem_req)
iord  output  1  memory address select: 0 = PC, 1 = ALU result register
ir_we  output  1  instruction register load
mdr_we  output  1  memory data register load
pc_we  output  1  PC load
pc_src  output  2  00 = PC+4, 01 = branch target, 10 = jump target {PC[31:28], addr26, 00}, 11 = rs (JR)
reg_we  output  1  register file write
reg_dst  output  2  00 = rt, 01 = rd, 10 = r31
wb_sel  output  2  00 = ALU, 01 = MDR, 10 = PC (link)
alu_src_b  output  2  00 = rt, 01 = sign-extended imm16, 10 = zero-extended imm16
alu_op  output  3  000 = ADD, 001 = SUB, 010 = XOR, 011 = SLT
retire  output  1  one-cycle pulse when an instruction completes
fault  output  2  00 = none, 01 = illegal instruction, 10 = memory timeout; sticky

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: on the clk edge with reset=1, state <= FETCH, latched op/funct <= 0, timeout counter <= 0, fault <= 00.
  - While reset=1, all outputs are forced to 0.
- Supported instructions: LW 100011, SW 101011, J 000010, JAL 000011, BNE 000101, ADDI 001000, XORI 001110.
  - R-type (op 000000) with funct ADD 100000, SUB 100010, SLT 101010, JR 001000.
  - Anything else is illegal.
- Outputs are Moore-decoded from state and latched op/funct, plus mem_ack/zero where noted. Unlisted outputs are 0.
- States and transitions:
  - FETCH: mem_req=1, iord=0.
    - On mem_ack: ir_we=1, pc_we=1, pc_src=00, then -> DECODE.
    - Without ack: hold.
  - DECODE: latch op/funct.
    - J: pc_we=1, pc_src=10, retire=1, -> FETCH.
    - JR: pc_we=1, pc_src=11, retire=1, -> FETCH.
    - JAL: -> WB.
    - Illegal: fault=01, -> HALT.
    - Otherwise: -> EXEC.
  - EXEC:
    - LW/SW: alu_op=000, alu_src_b=01, -> MEM.
    - ADDI: alu_op 000, alu_src_b 01, -> WB.
    - XORI: alu_op 010, alu_src_b 10, -> WB.
    - R-type: alu_src_b=00, alu_op per funct, -> WB.
    - BNE: alu_op=001, alu_src_b=00; if zero=0 then pc_we=1, pc_src=01; retire=1, -> FETCH.
  - MEM: mem_req=1, iord=1, mem_we=1 for SW.
    - On ack, LW: mdr_we=1, -> WB.
    - On ack, SW: retire=1, -> FETCH.
    - Without ack: hold with all signals stable.
  - WB: reg_we=1, retire=1, -> FETCH.
    - R-type: reg_dst=01, wb_sel=00.
    - ADDI/XORI: reg_dst=00, wb_sel=00.
    - LW: reg_dst=00, wb_sel=01.
    - JAL: reg_dst=10, wb_sel=10, and simultaneously pc_we=1, pc_src=10. The link value is the PC register before this edge, already PC+4.
  - HALT: all strobes 0, fault held. Exit only via reset.
- Latency with single-cycle ack: J/JR 2 cycles; JAL/BNE 3; R-type/ADDI/XORI/SW 4; LW 5. Each extra wait cycle on mem_ack adds one cycle.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - When it reaches TIMEOUT with no ack that cycle: fault=10, -> HALT.
  - Ack on the same cycle as the limit wins.
- mem_ack outside FETCH/MEM is ignored.
- Reset mid-operation aborts immediately. No pending write survives, because mem_req is forced to 0.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: adds output ports instr_count (32) and stall_count (32). Both reset to 0.
  - instr_count increments on every retire pulse.
  - stall_count increments on each FETCH/MEM cycle with mem_req=1 and mem_ack=0.
  - Both wrap at 2^32-1 -> 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD (op 000000, funct 100000), mem_ack always 1 -> states FETCH, DECODE, EXEC, WB. reg_we=1, reg_dst=01, alu_op=000 in WB. retire on cycle 4.
- LW (op 100011) with mem_ack delayed 3 cycles in MEM -> mem_req=1, iord=1 held 4 cycles. mdr_we on the ack cycle. WB reg_dst=00, wb_sel=01. Total 8 cycles.
- BNE (op 000101) with zero=0, then zero=1 -> pc_we=1, pc_src=01 in EXEC only for zero=0. retire on cycle 3 both times.
- JAL (op 000011) -> WB cycle has reg_we=1, reg_dst=10, wb_sel=10, pc_we=1, pc_src=10. Also J (op 000010) retires in 2 cycles.
- Illegal op 111111 -> fault=01 and HALT with all strobes 0 for 20 cycles. reset=1 for one cycle -> FETCH, fault=00.
- TIMEOUT=4, mem_ack held 0 in FETCH -> fault=10 after the 4th wait cycle. Separately, reset asserted mid-MEM of SW -> mem_req/mem_we drop to 0 that cycle.
